// File: rtl/spike_demux_collector_pkg.sv
// Shared definitions for the two-network spike multiplexer and its collector.
package spike_mux_pkg;

  localparam int NNET = 2;

  typedef enum logic {
    NET1 = 1'b0,
    NET2 = 1'b1
  } net_sel_t;

  // All-ones marker for a neuron that never fired; caller truncates to TW bits.
  function automatic logic [31:0] tstamp_none(input int tw);
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_demux_collector_tracker.sv
// Per-network first-spike recorder with gamma-boundary latch.
// Optional winner-take-all readout when SPIKE_DEMUX_WTA_EN is defined.
module first_spike_tracker
  import spike_mux_pkg::*;
#(
  parameter  int Q  = 2,
  parameter  int TW = 4,
  localparam int WW = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  grst,
  input  logic                  i_en,
  input  logic [Q-1:0]          i_spikes,
  input  logic [TW-1:0]         i_step,
`ifdef SPIKE_DEMUX_WTA_EN
  output logic [WW-1:0]         o_winner,
  output logic                  o_winnerVld,
`endif
  output logic [Q-1:0]          o_fired,
  output logic [Q-1:0][TW-1:0]  o_time
);

  localparam logic [31:0]   TS_NONE_W = tstamp_none(TW);
  localparam logic [TW-1:0] TS_NONE   = TS_NONE_W[TW-1:0];

  logic [Q-1:0]          r_sticky;
  logic [Q-1:0][TW-1:0]  r_tstamp;
  logic [Q-1:0]          w_hit;
  logic [Q-1:0]          w_stickyNext;
  logic [Q-1:0][TW-1:0]  w_tstampNext;

  // Next-state view includes the current cycle so a grst-cycle spike lands in the old gamma.
  always_comb begin
    w_hit        = i_en ? i_spikes : '0;
    w_stickyNext = r_sticky | w_hit;
    w_tstampNext = r_tstamp;
    for (int q = 0; q < Q; q++) begin
      if (w_hit[q] && !r_sticky[q]) w_tstampNext[q] = i_step;
    end
  end

`ifdef SPIKE_DEMUX_WTA_EN
  logic [WW-1:0] w_winIdx;
  logic [TW-1:0] w_winTime;
  logic          w_winVld;

  // Strict less-than keeps the lowest index on equal times.
  always_comb begin
    w_winIdx  = '0;
    w_winTime = TS_NONE;
    w_winVld  = 1'b0;
    for (int q = 0; q < Q; q++) begin
      if (w_stickyNext[q] && (!w_winVld || (w_tstampNext[q] < w_winTime))) begin
        w_winVld  = 1'b1;
        w_winIdx  = WW'(q);
        w_winTime = w_tstampNext[q];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sticky    <= '0;
      r_tstamp    <= '0;
      o_fired     <= '0;
      o_time      <= '0;
`ifdef SPIKE_DEMUX_WTA_EN
      o_winner    <= '0;
      o_winnerVld <= 1'b0;
`endif
    end else if (grst) begin
      o_fired <= w_stickyNext;
      for (int q = 0; q < Q; q++) begin
        o_time[q] <= w_stickyNext[q] ? w_tstampNext[q] : TS_NONE;
      end
`ifdef SPIKE_DEMUX_WTA_EN
      o_winner    <= w_winIdx;
      o_winnerVld <= w_winVld;
`endif
      r_sticky <= '0;
      r_tstamp <= '0;
    end else begin
      r_sticky <= w_stickyNext;
      r_tstamp <= w_tstampNext;
    end
  end

endmodule

// File: rtl/spike_demux_collector.sv
// De-interleaves the shared column's spikes into two networks and collects first-spike times.
// Optional winner outputs when SPIKE_DEMUX_WTA_EN is defined.
module spike_demux_collector
  import spike_mux_pkg::*;
#(
  parameter  int Q  = 2,
  parameter  int TW = 4,
  localparam int WW = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  grst,
  input  logic [Q-1:0]          col_spikes,
  output logic [Q-1:0]          spikes_net1,
  output logic [Q-1:0]          spikes_net2,
  output logic [Q-1:0]          fired_net1,
  output logic [Q-1:0]          fired_net2,
  output logic [Q-1:0][TW-1:0]  time_net1,
  output logic [Q-1:0][TW-1:0]  time_net2,
`ifdef SPIKE_DEMUX_WTA_EN
  output logic [WW-1:0]         winner_net1,
  output logic [WW-1:0]         winner_net2,
  output logic                  winner_vld_net1,
  output logic                  winner_vld_net2,
`endif
  output logic                  gamma_done
);

  localparam logic [31:0]   STEP_MAX_W = tstamp_none(TW);
  localparam logic [TW-1:0] STEP_MAX   = STEP_MAX_W[TW-1:0];

  net_sel_t      r_slot;
  logic [TW-1:0] r_step;

  // Step advances once per net1/net2 pair, i.e. on the net2 -> net1 slot change.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_slot      <= NET1;
      r_step      <= '0;
      spikes_net1 <= '0;
      spikes_net2 <= '0;
      gamma_done  <= 1'b0;
    end else begin
      gamma_done <= grst;
      if (grst) begin
        r_slot      <= NET1;
        r_step      <= '0;
        spikes_net1 <= '0;
        spikes_net2 <= '0;
      end else begin
        r_slot <= (r_slot == NET1) ? NET2 : NET1;
        if (r_slot == NET2 && r_step != STEP_MAX) r_step <= r_step + 1'b1;
        if (r_slot == NET1) spikes_net1 <= col_spikes;
        else                spikes_net2 <= col_spikes;
      end
    end
  end

  first_spike_tracker #(.Q(Q), .TW(TW)) u_trackNet1 (
    .clk         (clk),
    .rstb        (rstb),
    .grst        (grst),
    .i_en        (r_slot == NET1),
    .i_spikes    (col_spikes),
    .i_step      (r_step),
`ifdef SPIKE_DEMUX_WTA_EN
    .o_winner    (winner_net1),
    .o_winnerVld (winner_vld_net1),
`endif
    .o_fired     (fired_net1),
    .o_time      (time_net1)
  );

  first_spike_tracker #(.Q(Q), .TW(TW)) u_trackNet2 (
    .clk         (clk),
    .rstb        (rstb),
    .grst        (grst),
    .i_en        (r_slot == NET2),
    .i_spikes    (col_spikes),
    .i_step      (r_step),
`ifdef SPIKE_DEMUX_WTA_EN
    .o_winner    (winner_net2),
    .o_winnerVld (winner_vld_net2),
`endif
    .o_fired     (fired_net2),
    .o_time      (time_net2)
  );

endmodule

// File: tb/tb_spike_demux_collector.sv
// Directed bench for spike_demux_collector with a cycle-index model of both networks.
// Winner checks are included when SPIKE_DEMUX_WTA_EN is defined.
module tb_spike_demux_collector;

  localparam int Q  = 2;
  localparam int TW = 4;

  logic             clk = 1'b0;
  logic             rstb;
  logic             grst;
  logic [Q-1:0]     col_spikes;
  logic [Q-1:0]     spikes_net1, spikes_net2, fired_net1, fired_net2;
  logic [Q-1:0][TW-1:0] time_net1, time_net2;
  logic             gamma_done;
`ifdef SPIKE_DEMUX_WTA_EN
  logic [0:0]       winner_net1, winner_net2;
  logic             winner_vld_net1, winner_vld_net2;
`endif

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn   = 1'b0;

  // Model: first-spike step per network/neuron (-1 = none) and cycle index inside the gamma.
  int mFirst[2][Q];
  int mCyc;
  logic [Q-1:0]         eSp1, eSp2, eFired1, eFired2;
  logic [Q-1:0][TW-1:0] eTime1, eTime2;
  logic                 eDone;
  logic [0:0]           eWin1, eWin2;
  logic                 eWinV1, eWinV2;

  spike_demux_collector #(.Q(Q), .TW(TW)) dut (
    .clk             (clk),
    .rstb            (rstb),
    .grst            (grst),
    .col_spikes      (col_spikes),
    .spikes_net1     (spikes_net1),
    .spikes_net2     (spikes_net2),
    .fired_net1      (fired_net1),
    .fired_net2      (fired_net2),
    .time_net1       (time_net1),
    .time_net2       (time_net2),
`ifdef SPIKE_DEMUX_WTA_EN
    .winner_net1     (winner_net1),
    .winner_net2     (winner_net2),
    .winner_vld_net1 (winner_vld_net1),
    .winner_vld_net2 (winner_vld_net2),
`endif
    .gamma_done      (gamma_done)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int n = 0; n < 2; n++)
      for (int q = 0; q < Q; q++) mFirst[n][q] = -1;
    mCyc = 0;
    eSp1 = '0; eSp2 = '0; eFired1 = '0; eFired2 = '0;
    eTime1 = '0; eTime2 = '0; eDone = 1'b0;
    eWin1 = '0; eWin2 = '0; eWinV1 = 1'b0; eWinV2 = 1'b0;
  endtask

  // Returns the lowest-index neuron with the smallest first-spike step, or -1.
  function automatic int bestOf(input int n);
    int best = -1;
    for (int q = 0; q < Q; q++)
      if (mFirst[n][q] >= 0 && (best < 0 || mFirst[n][q] < mFirst[n][best])) best = q;
    return best;
  endfunction

  task automatic modelStep(input logic [Q-1:0] cs, input logic g);
    int slot = mCyc % 2;
    int step = (mCyc / 2 > 15) ? 15 : mCyc / 2;
    int b;
    for (int q = 0; q < Q; q++)
      if (cs[q] && mFirst[slot][q] < 0) mFirst[slot][q] = step;
    if (g) begin
      eSp1 = '0; eSp2 = '0; eDone = 1'b1;
      for (int q = 0; q < Q; q++) begin
        eFired1[q] = (mFirst[0][q] >= 0);
        eFired2[q] = (mFirst[1][q] >= 0);
        eTime1[q]  = (mFirst[0][q] >= 0) ? 4'(mFirst[0][q]) : 4'hF;
        eTime2[q]  = (mFirst[1][q] >= 0) ? 4'(mFirst[1][q]) : 4'hF;
      end
      b = bestOf(0); eWinV1 = (b >= 0); eWin1 = (b >= 0) ? 1'(b) : 1'b0;
      b = bestOf(1); eWinV2 = (b >= 0); eWin2 = (b >= 0) ? 1'(b) : 1'b0;
      for (int n = 0; n < 2; n++)
        for (int q = 0; q < Q; q++) mFirst[n][q] = -1;
      mCyc = 0;
    end else begin
      eDone = 1'b0;
      if (slot == 0) eSp1 = cs;
      else           eSp2 = cs;
      if (mCyc < 1000) mCyc++;
    end
  endtask

  // Drives one cycle of inputs, waits past the edge, then advances the model.
  task automatic applyStimulus(input logic [Q-1:0] cs, input logic g);
    col_spikes = cs;
    grst       = g;
    @(posedge clk);
    #1;
    modelStep(cs, g);
    col_spikes = '0;
    grst       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0);
  endtask

  task automatic checkOutput();
    cmp("spikes_net1", 32'(spikes_net1), 32'(eSp1));
    cmp("spikes_net2", 32'(spikes_net2), 32'(eSp2));
    cmp("fired_net1",  32'(fired_net1),  32'(eFired1));
    cmp("fired_net2",  32'(fired_net2),  32'(eFired2));
    cmp("time_net1",   32'(time_net1),   32'(eTime1));
    cmp("time_net2",   32'(time_net2),   32'(eTime2));
    cmp("gamma_done",  32'(gamma_done),  32'(eDone));
`ifdef SPIKE_DEMUX_WTA_EN
    cmp("winner_net1",     32'(winner_net1),     32'(eWin1));
    cmp("winner_net2",     32'(winner_net2),     32'(eWin2));
    cmp("winner_vld_net1", 32'(winner_vld_net1), 32'(eWinV1));
    cmp("winner_vld_net2", 32'(winner_vld_net2), 32'(eWinV2));
`endif
  endtask

  always @(negedge clk) begin
    if (chkEn) checkOutput();
  end

  initial begin
    rstb = 1'b0; grst = 1'b0; col_spikes = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_done",  32'(gamma_done), 32'h0);
    cmp("rst_time1", 32'(time_net1),  32'h00);
    chkEn = 1'b1;
    rstb  = 1'b1;

    // Idle gamma, grst at cycle 10
    idle(10);
    applyStimulus('0, 1'b1);
    cmp("idle_done",   32'(gamma_done), 32'h1);
    cmp("idle_fired1", 32'(fired_net1), 32'h0);
    cmp("idle_fired2", 32'(fired_net2), 32'h0);
    cmp("idle_time1",  32'(time_net1),  32'hFF);
    cmp("idle_time2",  32'(time_net2),  32'hFF);

    // net1 n0 at step 2 (cycle 4), net2 n1 at step 3 (cycle 7)
    idle(4);
    applyStimulus(2'b01, 1'b0);
    idle(2);
    applyStimulus(2'b10, 1'b0);
    cmp("demux_sp2", 32'(spikes_net2), 32'h2);
    idle(2);
    applyStimulus('0, 1'b1);
    cmp("basic_fired1", 32'(fired_net1), 32'h1);
    cmp("basic_time1",  32'(time_net1),  32'hF2);
    cmp("basic_fired2", 32'(fired_net2), 32'h2);
    cmp("basic_time2",  32'(time_net2),  32'h3F);
`ifdef SPIKE_DEMUX_WTA_EN
    cmp("basic_win2", 32'(winner_net2), 32'h1);
`endif

    // net1 n0 at steps 1 and 5; n1 spikes in the grst cycle (step 6)
    idle(2);
    applyStimulus(2'b01, 1'b0);
    idle(7);
    applyStimulus(2'b01, 1'b0);
    cmp("repeat_sp1", 32'(spikes_net1), 32'h1);
    idle(1);
    applyStimulus(2'b10, 1'b1);
    cmp("grstcyc_fired1", 32'(fired_net1), 32'h3);
    cmp("grstcyc_time1",  32'(time_net1),  32'h61);

    // Back-to-back grst: first carries a slot-0/step-0 spike, second is empty
    applyStimulus(2'b01, 1'b1);
    cmp("b2b_time1a", 32'(time_net1), 32'hF0);
    applyStimulus('0, 1'b1);
    cmp("b2b_fired1", 32'(fired_net1), 32'h0);
    cmp("b2b_time1b", 32'(time_net1),  32'hFF);
    cmp("b2b_done",   32'(gamma_done), 32'h1);

    // Tie on net1 at step 3, net2 silent
    idle(6);
    applyStimulus(2'b11, 1'b0);
    idle(1);
    applyStimulus('0, 1'b1);
    cmp("tie_time1", 32'(time_net1), 32'h33);
`ifdef SPIKE_DEMUX_WTA_EN
    cmp("tie_win1",  32'(winner_net1),     32'h0);
    cmp("tie_vld1",  32'(winner_vld_net1), 32'h1);
    cmp("tie_vld2",  32'(winner_vld_net2), 32'h0);
`endif

    // Saturation: net2 spike at cycle 41 (step saturated at 15)
    idle(41);
    applyStimulus(2'b01, 1'b0);
    applyStimulus('0, 1'b1);
    cmp("sat_fired2", 32'(fired_net2), 32'h1);
    cmp("sat_time2",  32'(time_net2),  32'hFF);
    cmp("sat_fired1", 32'(fired_net1), 32'h0);

    // Reset mid-gamma discards partial state
    idle(3);
    applyStimulus(2'b11, 1'b0);
    rstb = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    cmp("midrst_done",   32'(gamma_done), 32'h0);
    cmp("midrst_fired2", 32'(fired_net2), 32'h0);
    rstb = 1'b1;
    idle(5);
    applyStimulus('0, 1'b1);
    cmp("postrst_fired2", 32'(fired_net2), 32'h0);
    cmp("postrst_time2",  32'(time_net2),  32'hFF);
    cmp("postrst_done",   32'(gamma_done), 32'h1);

    idle(2);
    @(negedge clk);
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
